// File: rtl/mem_resp_pp.sv
// Far-end data-memory responder for the ping-pong address interface.
// Memory is cleared after reset; then single-cycle writes and registered reads with range and phase checking.
module mem_resp_pp #(
  parameter int SIZE_ADDR  = 24,
  parameter int SIZE_DATA  = 24,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                 iw_clk,
  input  logic                 iw_rst,
  input  logic                 iw_mem_mp,
  input  logic [SIZE_ADDR-1:0] iw_mem_addr0,
  input  logic [SIZE_ADDR-1:0] iw_mem_addr1,
  input  logic                 iw_mem_req,
  input  logic                 iw_mem_we,
  input  logic [SIZE_DATA-1:0] iw_mem_wdata,
  output logic                 ow_ready,
  output logic                 ow_rvalid,
  output logic [SIZE_DATA-1:0] ow_rdata,
  output logic                 ow_fault,
  output logic                 ow_phase_err,
  output logic                 ow_drop
);

  // state   | meaning
  // ST_INIT | clearing word[cnt_q] each cycle, requests are dropped
  // ST_RUN  | accepting accesses; left only through reset
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
  logic                  prev_mp_q;
  logic                  rvalid_q, rvalid_d;
  logic                  fault_q, fault_d;
  logic                  phase_err_q, phase_err_d;
  logic                  drop_q, drop_d;
  logic [SIZE_DATA-1:0]  rdata_q, rdata_d;

  logic [SIZE_DATA-1:0]  mem [DEPTH];

  logic [SIZE_ADDR-1:0]  live_addr;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  acc;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic [SIZE_DATA-1:0]  mem_wdata;

  always_comb begin
    live_addr   = iw_mem_mp ? iw_mem_addr0 : iw_mem_addr1;
    in_range    = (live_addr[SIZE_ADDR-1:DEPTH_LOG2] == '0);
    idx         = live_addr[DEPTH_LOG2-1:0];
    acc         = (state_q == ST_RUN) && iw_mem_req;
    state_d     = state_q;
    cnt_d       = cnt_q;
    rvalid_d    = acc && !iw_mem_we;
    fault_d     = acc && !in_range;
    rdata_d     = rdata_q;
    phase_err_d = phase_err_q;
    drop_d      = drop_q;
    mem_we      = 1'b0;
    mem_idx     = idx;
    mem_wdata   = iw_mem_wdata;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_idx   = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = ST_RUN;
        if (iw_mem_req) drop_d = 1'b1;
      end
      ST_RUN: begin
        if (iw_mem_mp == prev_mp_q) phase_err_d = 1'b1;
        if (iw_mem_req && iw_mem_we && in_range) mem_we = 1'b1;
        // out-of-range reads return zero alongside the fault pulse
        if (acc && !iw_mem_we) rdata_d = in_range ? mem[idx] : '0;
      end
      default: state_d = ST_INIT;
    endcase
    if (iw_rst) mem_we = 1'b0;
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      prev_mp_q   <= 1'b1;
      rvalid_q    <= 1'b0;
      fault_q     <= 1'b0;
      phase_err_q <= 1'b0;
      drop_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_mp_q   <= iw_mem_mp;
      rvalid_q    <= rvalid_d;
      fault_q     <= fault_d;
      phase_err_q <= phase_err_d;
      drop_q      <= drop_d;
      rdata_q     <= rdata_d;
    end
  end

  always_ff @(posedge iw_clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  assign ow_ready     = (state_q == ST_RUN);
  assign ow_rvalid    = rvalid_q;
  assign ow_rdata     = rdata_q;
  assign ow_fault     = fault_q;
  assign ow_phase_err = phase_err_q;
  assign ow_drop      = drop_q;

endmodule

// File: tb/tb_mem_resp_pp.sv
// Directed bench for mem_resp_pp with DEPTH 16; a driver queues expected responses,
// and a negedge monitor pops and compares them against the response outputs.
module tb_mem_resp_pp;

  logic        clk;
  logic        iw_rst;
  logic        iw_mem_mp;
  logic [23:0] iw_mem_addr0;
  logic [23:0] iw_mem_addr1;
  logic        iw_mem_req;
  logic        iw_mem_we;
  logic [23:0] iw_mem_wdata;
  logic        ow_ready;
  logic        ow_rvalid;
  logic [23:0] ow_rdata;
  logic        ow_fault;
  logic        ow_phase_err;
  logic        ow_drop;

  mem_resp_pp #(.SIZE_ADDR(24), .SIZE_DATA(24), .DEPTH_LOG2(4)) dut (
    .iw_clk       (clk),
    .iw_rst       (iw_rst),
    .iw_mem_mp    (iw_mem_mp),
    .iw_mem_addr0 (iw_mem_addr0),
    .iw_mem_addr1 (iw_mem_addr1),
    .iw_mem_req   (iw_mem_req),
    .iw_mem_we    (iw_mem_we),
    .iw_mem_wdata (iw_mem_wdata),
    .ow_ready     (ow_ready),
    .ow_rvalid    (ow_rvalid),
    .ow_rdata     (ow_rdata),
    .ow_fault     (ow_fault),
    .ow_phase_err (ow_phase_err),
    .ow_drop      (ow_drop)
  );

  typedef struct {
    int          due;
    logic        rv;
    logic [23:0] data;
    logic        flt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;
  logic mp_cur = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: one comparison per cycle, either against the due entry or against idle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        mon_e = exp_q.pop_front();
        n_chk++;
        if (ow_rvalid !== mon_e.rv || ow_fault !== mon_e.flt ||
            (mon_e.rv && ow_rdata !== mon_e.data)) begin
          n_fail++;
          $display("FAIL resp@%0d: got rvalid=%b fault=%b rdata=%h, required rvalid=%b fault=%b rdata=%h",
                   cyc, ow_rvalid, ow_fault, ow_rdata, mon_e.rv, mon_e.flt, mon_e.data);
        end
      end else begin
        n_chk++;
        if (ow_rvalid !== 1'b0 || ow_fault !== 1'b0) begin
          n_fail++;
          $display("FAIL idle@%0d: got rvalid=%b fault=%b, required 0 0", cyc, ow_rvalid, ow_fault);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic cyc_drv(input logic rst, input logic mp, input logic [23:0] a0, input logic [23:0] a1,
                         input logic req, input logic we, input logic [23:0] wd,
                         input logic erv, input logic [23:0] edata, input logic eflt);
    @(negedge clk);
    iw_rst       = rst;
    iw_mem_mp    = mp;
    iw_mem_addr0 = a0;
    iw_mem_addr1 = a1;
    iw_mem_req   = req;
    iw_mem_we    = we;
    iw_mem_wdata = wd;
    mp_cur       = mp;
    if (erv || eflt) exp_q.push_back('{cyc + 1, erv, edata, eflt});
  endtask

  // Toggles the phase; the live port gets addr, the other port a decoy address.
  task automatic acc(input logic [23:0] addr, input logic req, input logic we, input logic [23:0] wd,
                     input logic erv, input logic [23:0] edata, input logic eflt);
    logic        mp;
    logic [23:0] other;
    mp    = ~mp_cur;
    other = addr ^ 24'h00000C;
    cyc_drv(1'b0, mp, mp ? addr : other, mp ? other : addr, req, we, wd, erv, edata, eflt);
  endtask

  task automatic idle();
    acc(24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic rd(input logic [23:0] addr, input logic [23:0] edata, input logic eflt);
    acc(addr, 1'b1, 1'b0, 24'h0, 1'b1, edata, eflt);
  endtask

  task automatic wr(input logic [23:0] addr, input logic [23:0] wd, input logic eflt);
    acc(addr, 1'b1, 1'b1, wd, 1'b0, 24'h0, eflt);
  endtask

  // Counts cycles with ow_ready low, starting at the first cycle after reset.
  task automatic count_init(input string name);
    int n;
    n = 0;
    while (!ow_ready && n < 100) begin
      n++;
      idle();
    end
    chk(name, 24'(n), 24'd16);
  endtask

  initial begin
    iw_rst = 1'b1; iw_mem_mp = 1'b1; iw_mem_addr0 = '0; iw_mem_addr1 = '0;
    iw_mem_req = 1'b0; iw_mem_we = 1'b0; iw_mem_wdata = '0;

    // Reset and initial clear
    cyc_drv(1'b1, 1'b1, 24'h0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
    idle();
    chk("rst_ready", 24'(ow_ready), 24'h0);
    chk("rst_rvalid", 24'(ow_rvalid), 24'h0);
    chk("rst_rdata", ow_rdata, 24'h0);
    chk("rst_fault", 24'(ow_fault), 24'h0);
    chk("rst_phase_err", 24'(ow_phase_err), 24'h0);
    chk("rst_drop", 24'(ow_drop), 24'h0);
    mon_en = 1'b1;
    count_init("init_len");
    for (int i = 0; i < 16; i++) rd(24'(i), 24'h000000, 1'b0);

    // Port select: write via port 0, read back via port 1
    if (mp_cur == 1'b1) idle();
    cyc_drv(1'b0, 1'b1, 24'd5, 24'd9, 1'b1, 1'b1, 24'hABCDEF, 1'b0, 24'h0, 1'b0);
    cyc_drv(1'b0, 1'b0, 24'd9, 24'd5, 1'b1, 1'b0, 24'h0, 1'b1, 24'hABCDEF, 1'b0);
    idle();
    chk("rdata_hold", ow_rdata, 24'hABCDEF);
    rd(24'd9, 24'h000000, 1'b0);

    // Read-after-write back to back on word 3
    rd(24'd3, 24'h000000, 1'b0);
    wr(24'd3, 24'h000123, 1'b0);
    rd(24'd3, 24'h000123, 1'b0);

    // Out-of-range accesses
    wr(24'h000010, 24'h555555, 1'b1);
    rd(24'h000010, 24'h000000, 1'b1);
    rd(24'd0, 24'h000000, 1'b0);
    rd(24'h100005, 24'h000000, 1'b1);
    rd(24'd15, 24'h000000, 1'b0);
    idle();
    idle();

    // Phase violation: repeated phase, access still served from the live port
    chk("phase_err_clean", 24'(ow_phase_err), 24'h0);
    cyc_drv(1'b0, mp_cur, mp_cur ? 24'd5 : 24'd12, mp_cur ? 24'd12 : 24'd5,
            1'b1, 1'b0, 24'h0, 1'b1, 24'hABCDEF, 1'b0);
    idle();
    chk("phase_err_set", 24'(ow_phase_err), 24'h1);
    idle();
    idle();
    chk("phase_err_sticky", 24'(ow_phase_err), 24'h1);

    // Reset with a read request in the same cycle: no response, flags cleared
    cyc_drv(1'b1, ~mp_cur, 24'd5, 24'd5, 1'b1, 1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
    idle();
    chk("phase_err_cleared", 24'(ow_phase_err), 24'h0);
    chk("drop_after_rst", 24'(ow_drop), 24'h0);
    chk("ready_after_rst", 24'(ow_ready), 24'h0);
    count_init("init_len_2");

    // Request during INIT, then reset mid-INIT
    cyc_drv(1'b1, ~mp_cur, 24'h0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
    for (int i = 0; i < 5; i++) idle();
    wr(24'd5, 24'hFFFFFF, 1'b0);
    idle();
    idle();
    chk("drop_set", 24'(ow_drop), 24'h1);
    chk("ready_in_init", 24'(ow_ready), 24'h0);
    cyc_drv(1'b1, ~mp_cur, 24'h0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
    idle();
    chk("drop_cleared", 24'(ow_drop), 24'h0);
    count_init("init_len_3");
    rd(24'd5, 24'h000000, 1'b0);
    rd(24'd3, 24'h000000, 1'b0);
    wr(24'd15, 24'h00F00D, 1'b0);
    rd(24'd15, 24'h00F00D, 1'b0);
    idle();
    idle();
    chk("drop_stays_clear", 24'(ow_drop), 24'h0);
    chk("phase_err_final", 24'(ow_phase_err), 24'h0);
    chk("queue_drained", 24'(exp_q.size()), 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
